pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the team's ripple-carry full-adder chain.
- Splits a WIDTH-bit add/subtract into STAGES carry-chained slices, one slice per clock.
- Carries the upper-slice operands and the partial sum down a registered pipeline with valid/ready flow control on both ends.
- Sits between operand producers, such as the ALU issue or accumulator front-ends, and any consumer that may apply backpressure.

---
 rtl/pipelined_adder_if.sv | 27 ++
 rtl/pipelined_adder.sv | 155 +++++++++++++++
 tb/tb_pipelined_adder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_adder_if.sv
// pipelined_adder_if: operand and result handshake bundle for pipelined_adder.
// master is the producer/consumer side, slave is the adder itself.
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, carry_in, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, carry_in, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract split into STAGES carry-chained
// slices, one slice per clock. Each stage carries the partial sum, the slice
// carry and the operand bits still to be added. Valid/ready flow control on
// both ends; bubbles collapse so a full pipe sustains one beat per cycle.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);

  localparam int SLICE = (STAGES > 0) ? (WIDTH / STAGES) : 1;

  // Reject configurations that cannot be cut into equal slices.
  if (WIDTH < 1) begin : g_bad_width
    $error("pipelined_adder: WIDTH must be at least 1");
  end
  if (STAGES < 1) begin : g_bad_stages
    $error("pipelined_adder: STAGES must be at least 1");
  end else if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipelined_adder: WIDTH must be a multiple of STAGES");
  end

  // Subtraction is a + ~b + ~borrow_in, so only b and the carry get inverted.
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub ^ bus.carry_in;

  logic [STAGES-1:0] stage_valid;
  logic [STAGES:0]   stage_ready;

  // A stage may load when it is empty or its own beat leaves this cycle.
  always_comb begin
    stage_ready[STAGES] = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_ready[k] = ~stage_valid[k] | stage_ready[k + 1];
    end
  end

  assign bus.in_ready = stage_ready[0];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      // Low bits of the result known once this stage has added its slice.
      localparam int LO = (gi + 1) * SLICE;

      logic             v_src;
      logic [SLICE-1:0] a_sl;
      logic [SLICE-1:0] b_sl;
      logic             c_src;
      logic [SLICE:0]   slice_add;
      logic [LO-1:0]    sum_next;
      logic             valid_reg;
      logic             carry_reg;
      logic [LO-1:0]    sum_reg;

      // Narrow slice adder: SLICE bits plus one carry bit, nothing wider.
      assign slice_add = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, c_src};

      if (gi == 0) begin : g_src
        assign v_src    = bus.in_valid;
        assign a_sl     = bus.a[SLICE-1:0];
        assign b_sl     = b_eff[SLICE-1:0];
        assign c_src    = c0;
        assign sum_next = slice_add[SLICE-1:0];
      end else begin : g_src
        assign v_src    = g_stage[gi-1].valid_reg;
        assign a_sl     = g_stage[gi-1].g_fwd.a_reg[SLICE-1:0];
        assign b_sl     = g_stage[gi-1].g_fwd.b_reg[SLICE-1:0];
        assign c_src    = g_stage[gi-1].carry_reg;
        assign sum_next = {slice_add[SLICE-1:0], g_stage[gi-1].sum_reg};
      end

      assign stage_valid[gi] = valid_reg;

      // Advance the beat (or a bubble) whenever downstream lets this stage move.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          sum_reg   <= '0;
        end else if (stage_ready[gi]) begin
          valid_reg <= v_src;
          if (v_src) begin
            carry_reg <= slice_add[SLICE];
            sum_reg   <= sum_next;
          end
        end
      end

      // Every stage but the last forwards the operand bits not yet added.
      if (gi < STAGES - 1) begin : g_fwd
        localparam int REM = WIDTH - LO;

        logic [REM-1:0] a_up;
        logic [REM-1:0] b_up;
        logic [REM-1:0] a_reg;
        logic [REM-1:0] b_reg;

        if (gi == 0) begin : g_up
          assign a_up = bus.a[SLICE +: REM];
          assign b_up = b_eff[SLICE +: REM];
        end else begin : g_up
          assign a_up = g_stage[gi-1].g_fwd.a_reg[SLICE +: REM];
          assign b_up = g_stage[gi-1].g_fwd.b_reg[SLICE +: REM];
        end

        // Capture upper operand bits alongside the beat they belong to.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
          end else if (stage_ready[gi] && v_src) begin
            a_reg <= a_up;
            b_reg <= b_up;
          end
        end
      end

      // The last stage owns the result and the carry into the MSB.
      if (gi == STAGES - 1) begin : g_last
        logic msb_carry_next;
        logic msb_carry_reg;

        // Carry into the MSB recovered from the MSB sum bit and its operands.
        assign msb_carry_next = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ slice_add[SLICE-1];

        // Keep the MSB carry-in with the final slice for overflow detection.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            msb_carry_reg <= 1'b0;
          end else if (stage_ready[gi] && v_src) begin
            msb_carry_reg <= msb_carry_next;
          end
        end

        // Empty stage contents are stale, so outputs are forced to 0 when idle.
        assign bus.out_valid = valid_reg;
        assign bus.sum       = valid_reg ? sum_reg : '0;
        assign bus.carry_out = valid_reg & carry_reg;
        assign bus.overflow  = valid_reg & (msb_carry_reg ^ carry_reg);
      end
    end
  endgenerate

  // A stalled result must hold until the consumer takes it.
  a_hold_on_stall : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=>
      (bus.out_valid && $stable(bus.sum) && $stable(bus.carry_out) && $stable(bus.overflow)));

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed tests on an 8x2 instance plus a random
// scoreboard sweep across four further (WIDTH, STAGES) configurations.
module tb_pipelined_adder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Main 8-bit, 2-stage instance used by the directed tests.
  pipelined_adder_if #(.WIDTH(8)) if_main ();
  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(if_main));

  logic [9:0] exp_q[$];   // {overflow, carry_out, sum}

  // Sweep instances: (8,1) (8,4) (16,4) (32,8), driven through 32-bit arrays.
  logic        sw_valid  [4];
  logic        sw_ready  [4];
  logic        sw_cin    [4];
  logic        sw_sub    [4];
  logic [31:0] sw_a      [4];
  logic [31:0] sw_b      [4];
  logic        sw_iready [4];
  logic        sw_ovalid [4];
  logic [31:0] sw_sum    [4];
  logic        sw_cout   [4];
  logic        sw_ovf    [4];
  logic [65:0] sw_q [4][$];  // {issue cycle, overflow, carry_out, sum}

  pipelined_adder_if #(.WIDTH(8))  if_s0 ();
  pipelined_adder_if #(.WIDTH(8))  if_s1 ();
  pipelined_adder_if #(.WIDTH(16)) if_s2 ();
  pipelined_adder_if #(.WIDTH(32)) if_s3 ();

  pipelined_adder #(.WIDTH(8),  .STAGES(1)) dut_s0 (.clk(clk), .rst_n(rst_n), .bus(if_s0));
  pipelined_adder #(.WIDTH(8),  .STAGES(4)) dut_s1 (.clk(clk), .rst_n(rst_n), .bus(if_s1));
  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut_s2 (.clk(clk), .rst_n(rst_n), .bus(if_s2));
  pipelined_adder #(.WIDTH(32), .STAGES(8)) dut_s3 (.clk(clk), .rst_n(rst_n), .bus(if_s3));

  assign if_s0.in_valid = sw_valid[0];  assign if_s0.out_ready = sw_ready[0];
  assign if_s0.carry_in = sw_cin[0];    assign if_s0.sub       = sw_sub[0];
  assign if_s0.a        = sw_a[0][7:0]; assign if_s0.b         = sw_b[0][7:0];
  assign sw_iready[0] = if_s0.in_ready; assign sw_ovalid[0] = if_s0.out_valid;
  assign sw_sum[0] = {24'd0, if_s0.sum};
  assign sw_cout[0] = if_s0.carry_out;  assign sw_ovf[0] = if_s0.overflow;

  assign if_s1.in_valid = sw_valid[1];  assign if_s1.out_ready = sw_ready[1];
  assign if_s1.carry_in = sw_cin[1];    assign if_s1.sub       = sw_sub[1];
  assign if_s1.a        = sw_a[1][7:0]; assign if_s1.b         = sw_b[1][7:0];
  assign sw_iready[1] = if_s1.in_ready; assign sw_ovalid[1] = if_s1.out_valid;
  assign sw_sum[1] = {24'd0, if_s1.sum};
  assign sw_cout[1] = if_s1.carry_out;  assign sw_ovf[1] = if_s1.overflow;

  assign if_s2.in_valid = sw_valid[2];   assign if_s2.out_ready = sw_ready[2];
  assign if_s2.carry_in = sw_cin[2];     assign if_s2.sub       = sw_sub[2];
  assign if_s2.a        = sw_a[2][15:0]; assign if_s2.b         = sw_b[2][15:0];
  assign sw_iready[2] = if_s2.in_ready;  assign sw_ovalid[2] = if_s2.out_valid;
  assign sw_sum[2] = {16'd0, if_s2.sum};
  assign sw_cout[2] = if_s2.carry_out;   assign sw_ovf[2] = if_s2.overflow;

  assign if_s3.in_valid = sw_valid[3];  assign if_s3.out_ready = sw_ready[3];
  assign if_s3.carry_in = sw_cin[3];    assign if_s3.sub       = sw_sub[3];
  assign if_s3.a        = sw_a[3];      assign if_s3.b         = sw_b[3];
  assign sw_iready[3] = if_s3.in_ready; assign sw_ovalid[3] = if_s3.out_valid;
  assign sw_sum[3] = if_s3.sum;
  assign sw_cout[3] = if_s3.carry_out;  assign sw_ovf[3] = if_s3.overflow;

  // Reference: a - b - cin is a + ~b + (1 - cin); overflow from the sign rule.
  function automatic logic [33:0] ref_model(int w, logic [31:0] a, logic [31:0] b,
                                            logic cin, logic sub);
    logic [63:0] mask, bb, tot;
    logic [31:0] s;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    bb   = sub ? ((~{32'd0, b}) & mask) : {32'd0, b};
    tot  = {32'd0, a} + bb + (sub ? {63'd0, ~cin} : {63'd0, cin});
    s    = tot[31:0] & mask[31:0];
    co   = tot[w];
    ov   = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (if_main.out_valid !== 1'b0 || if_main.sum !== 8'h00 ||
        if_main.carry_out !== 1'b0 || if_main.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: out_valid=%b sum=%h cout=%b ovf=%b, required all zero",
               if_main.out_valid, if_main.sum, if_main.carry_out, if_main.overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if_main.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", if_main.in_ready);
    end
    $display("reset: released, in_ready=%b", if_main.in_ready);
  endtask

  task automatic test_arith();
    logic [7:0] va, vb, vs;
    logic       vc, vsub, vco, vov;
    logic [9:0] got, expv;
    int         lat;
    bit         seen;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       begin va = 8'hFF; vb = 8'h01; vc = 0; vsub = 0; vs = 8'h00; vco = 1; vov = 0; end
        1:       begin va = 8'h7F; vb = 8'h01; vc = 0; vsub = 0; vs = 8'h80; vco = 0; vov = 1; end
        2:       begin va = 8'h05; vb = 8'h07; vc = 0; vsub = 1; vs = 8'hFE; vco = 0; vov = 0; end
        default: begin va = 8'h80; vb = 8'h01; vc = 0; vsub = 1; vs = 8'h7F; vco = 1; vov = 1; end
      endcase
      @(negedge clk);
      if_main.out_ready = 1'b1;
      if_main.in_valid  = 1'b1;
      if_main.a = va; if_main.b = vb; if_main.carry_in = vc; if_main.sub = vsub;
      #1;
      n_checks++;
      if (if_main.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL arith_in_ready[%0d]: got %b, required 1", i, if_main.in_ready);
      end
      exp_q.push_back({vov, vco, vs});
      @(negedge clk);
      if_main.in_valid = 1'b0;
      lat  = 1;
      seen = 0;
      while (!seen && lat <= 10) begin
        if (if_main.out_valid === 1'b1) seen = 1;
        else begin
          @(negedge clk);
          lat++;
        end
      end
      n_checks++;
      if (!seen || lat != 2) begin
        n_fail++;
        $display("FAIL arith_latency[%0d]: got %0d cycles (seen=%0d), required 2", i, lat, seen);
      end
      expv = exp_q.pop_front();
      got  = {if_main.overflow, if_main.carry_out, if_main.sum};
      n_checks++;
      if (got !== expv) begin
        n_fail++;
        $display("FAIL arith_result[%0d]: got ovf=%b cout=%b sum=%h, required ovf=%b cout=%b sum=%h",
                 i, got[9], got[8], got[7:0], expv[9], expv[8], expv[7:0]);
      end
      $display("arith[%0d]: a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
               i, va, vb, vsub, vc, got[7:0], got[8], got[9], lat);
    end
  endtask

  task automatic test_backpressure();
    int         issued = 0;
    int         popped = 0;
    int         c = 0;
    logic [7:0] held = 8'h00;
    bit         stalled = 0;
    bit         saw_full = 0;
    logic       exp_ready;
    logic [9:0] expv, got;
    exp_q.delete();
    while (popped < 10 && c < 40) begin
      @(negedge clk);
      if_main.out_ready = !(c >= 3 && c <= 7);
      if_main.in_valid  = (issued < 10);
      if_main.a = 8'(issued + 1);
      if_main.b = 8'(2 * (issued + 1));
      if_main.carry_in = 1'b0;
      if_main.sub      = 1'b0;
      #1;
      exp_ready = if_main.out_ready || (exp_q.size() < 2);
      n_checks++;
      if (if_main.in_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL bp_in_ready[c=%0d]: got %b, required %b (occupancy %0d)",
                 c, if_main.in_ready, exp_ready, exp_q.size());
      end
      if (!if_main.in_ready && !if_main.out_ready) saw_full = 1;
      if (stalled) begin
        n_checks++;
        if (if_main.out_valid !== 1'b1 || if_main.sum !== held) begin
          n_fail++;
          $display("FAIL bp_hold[c=%0d]: got valid=%b sum=%h, required valid=1 sum=%h",
                   c, if_main.out_valid, if_main.sum, held);
        end
      end
      if (c >= 8 && popped < 10) begin
        n_checks++;
        if (if_main.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_gap[c=%0d]: got out_valid=%b, required 1", c, if_main.out_valid);
        end
      end
      if (if_main.out_valid === 1'b1 && if_main.out_ready) begin
        got = {if_main.overflow, if_main.carry_out, if_main.sum};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra[c=%0d]: got sum=%h, required no beat", c, got[7:0]);
        end else begin
          expv = exp_q.pop_front();
          if (got !== expv) begin
            n_fail++;
            $display("FAIL bp_result[%0d]: got sum=%h cout=%b ovf=%b, required sum=%h cout=0 ovf=0",
                     popped, got[7:0], got[8], got[9], expv[7:0]);
          end
        end
        $display("backpressure: beat %0d out sum=%h at c=%0d", popped, got[7:0], c);
        popped++;
      end
      stalled = (if_main.out_valid === 1'b1) && !if_main.out_ready;
      held    = if_main.sum;
      if (if_main.in_valid && if_main.in_ready === 1'b1) begin
        exp_q.push_back({2'b00, 8'(3 * (issued + 1))});
        issued++;
      end
      c++;
    end
    if_main.in_valid  = 1'b0;
    if_main.out_ready = 1'b1;
    n_checks++;
    if (popped != 10 || !saw_full) begin
      n_fail++;
      $display("FAIL bp_complete: got %0d beats, full=%0d, required 10 beats and full=1",
               popped, saw_full);
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    @(negedge clk);
    if_main.out_ready = 1'b0;
    if_main.in_valid  = 1'b1;
    if_main.a = 8'h7F; if_main.b = 8'h01; if_main.carry_in = 1'b0; if_main.sub = 1'b0;
    @(negedge clk);
    if_main.a = 8'hFF; if_main.b = 8'h01;
    @(negedge clk);
    if_main.in_valid = 1'b0;
    n_checks++;
    if (if_main.out_valid !== 1'b1 || if_main.sum !== 8'h80 || if_main.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: got valid=%b sum=%h ovf=%b, required valid=1 sum=80 ovf=1",
               if_main.out_valid, if_main.sum, if_main.overflow);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (if_main.out_valid !== 1'b0 || if_main.sum !== 8'h00 ||
        if_main.carry_out !== 1'b0 || if_main.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: got valid=%b sum=%h cout=%b ovf=%b, required all zero",
               if_main.out_valid, if_main.sum, if_main.carry_out, if_main.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    if_main.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_checks++;
        if (if_main.in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL rst_mid_ready: got %b, required 1", if_main.in_ready);
        end
      end
      n_checks++;
      if (if_main.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_stale[%0d]: got out_valid=%b sum=%h, required out_valid=0",
                 k, if_main.out_valid, if_main.sum);
      end
    end
    $display("reset_mid: in-flight beats discarded");
  endtask

  task automatic test_sweep();
    localparam int N = 10000;
    int          sw_w [4];
    int          sw_s [4];
    logic [31:0] mask [4];
    int          issued [4];
    int          popped [4];
    int          min_lat [4];
    int          cyc = 0;
    int          lat;
    bit          all_done = 0;
    logic [65:0] ent;
    logic [33:0] got;
    sw_w = '{8, 8, 16, 32};
    sw_s = '{1, 4, 4, 8};
    for (int c = 0; c < 4; c++) begin
      mask[c]    = (sw_w[c] == 32) ? 32'hFFFF_FFFF : ((32'd1 << sw_w[c]) - 32'd1);
      issued[c]  = 0;
      popped[c]  = 0;
      min_lat[c] = 1000000;
      sw_q[c].delete();
    end
    while (!all_done && cyc < 40000) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        sw_ready[c] = ($urandom_range(0, 99) < 70);
        sw_valid[c] = (issued[c] < N) && ($urandom_range(0, 99) < 70);
        sw_a[c]     = $urandom() & mask[c];
        sw_b[c]     = $urandom() & mask[c];
        sw_cin[c]   = 1'($urandom_range(0, 1));
        sw_sub[c]   = 1'($urandom_range(0, 1));
      end
      #1;
      all_done = 1;
      for (int c = 0; c < 4; c++) begin
        got = {sw_ovf[c], sw_cout[c], sw_sum[c]};
        if (sw_ovalid[c] === 1'b1 && sw_ready[c]) begin
          n_checks++;
          if (sw_q[c].size() == 0) begin
            n_fail++;
            $display("FAIL sweep_extra[cfg%0d]: got sum=%h, required no beat", c, got[31:0]);
          end else begin
            ent = sw_q[c].pop_front();
            lat = cyc - int'(ent[65:34]);
            if (lat < min_lat[c]) min_lat[c] = lat;
            if (got !== ent[33:0]) begin
              n_fail++;
              $display("FAIL sweep_result[cfg%0d beat %0d]: got ovf=%b cout=%b sum=%h, required ovf=%b cout=%b sum=%h",
                       c, popped[c], got[33], got[32], got[31:0], ent[33], ent[32], ent[31:0]);
            end
          end
          popped[c]++;
        end else if (sw_ovalid[c] !== 1'b1) begin
          n_checks++;
          if (got !== 34'd0) begin
            n_fail++;
            $display("FAIL sweep_idle_zero[cfg%0d]: got ovf=%b cout=%b sum=%h, required all zero",
                     c, got[33], got[32], got[31:0]);
          end
        end
        if (sw_valid[c] && sw_iready[c] === 1'b1) begin
          sw_q[c].push_back({32'(cyc), ref_model(sw_w[c], sw_a[c], sw_b[c], sw_cin[c], sw_sub[c])});
          issued[c]++;
        end
        if (popped[c] < N || issued[c] < N) all_done = 0;
      end
      cyc++;
    end
    for (int c = 0; c < 4; c++) sw_valid[c] = 1'b0;
    n_checks++;
    if (!all_done) begin
      n_fail++;
      $display("FAIL sweep_timeout: got %0d cycles without draining, required completion", cyc);
    end
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (min_lat[c] != sw_s[c] || popped[c] != N) begin
        n_fail++;
        $display("FAIL sweep_latency[cfg%0d]: got min latency %0d and %0d beats, required %0d and %0d",
                 c, min_lat[c], popped[c], sw_s[c], N);
      end
      $display("sweep: WIDTH=%0d STAGES=%0d beats=%0d min_latency=%0d",
               sw_w[c], sw_s[c], popped[c], min_lat[c]);
    end
  endtask

  initial begin
    if_main.in_valid  = 1'b0;
    if_main.out_ready = 1'b1;
    if_main.a         = 8'h00;
    if_main.b         = 8'h00;
    if_main.carry_in  = 1'b0;
    if_main.sub       = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sw_valid[c] = 1'b0;
      sw_ready[c] = 1'b1;
      sw_cin[c]   = 1'b0;
      sw_sub[c]   = 1'b0;
      sw_a[c]     = 32'd0;
      sw_b[c]     = 32'd0;
    end
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
